// File: rtl/code_entry_pkg.sv
// Shared state encoding and digit constants for the code entry controller.
// Build macro CODE_ENTRY_LOCKOUT_EN adds the LOCKOUT state.
package code_entry_pkg;

    localparam int                 DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        CHECK,
        OPEN,
        FAIL
`ifdef CODE_ENTRY_LOCKOUT_EN
        , LOCKOUT
`endif
    } state_e;

    // Decimal digit increment, wrapping 9 back to 0.
    function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
        return (d == MAX_DIGIT) ? '0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Digit-advance tick divider: one tick every TICK_DIV enabled clocks,
// phase restarts whenever enable drops.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_end;

    assign at_end = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign tick   = enable && at_end;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || at_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/code_entry_ctrl.sv
// Digit-by-digit code entry FSM with match check, timed error hold and relock.
// Build macro CODE_ENTRY_LOCKOUT_EN adds a long lockout after three straight failures.
module code_entry_ctrl
    import code_entry_pkg::*;
#(
    parameter int TICK_DIV    = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int FAIL_CYCLES = 8
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    enb_cnt,
    input  logic                    select,
    input  logic                    clear,
    input  logic [4*NUM_DIGITS-1:0] code_in,
    output logic [DIGIT_W-1:0]      digit,
    output logic [1:0]              entry_idx,
    output logic                    disable_cnt,
    output logic                    unlocked,
    output logic                    error
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);
`ifdef CODE_ENTRY_LOCKOUT_EN
    localparam int LOCK_CYCLES = 64 * FAIL_CYCLES;
    localparam int WAIT_MAX    = LOCK_CYCLES;
`else
    localparam int WAIT_MAX    = FAIL_CYCLES;
`endif
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_e               state_q, state_d;
    logic [DIGIT_W-1:0]   digit_q, digit_d;
    logic [1:0]           idx_q, idx_d;
    logic [DIGIT_W-1:0]   entry_q [NUM_DIGITS];
    logic [DIGIT_W-1:0]   entry_d [NUM_DIGITS];
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 unlocked_q, unlocked_d;
    logic                 error_q, error_d;
    logic                 disable_q, disable_d;
    logic                 code_match;
    logic                 tick;
`ifdef CODE_ENTRY_LOCKOUT_EN
    logic [1:0]           fails_q, fails_d;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst    (rst),
        .enable ((state_q == COUNT) && enb_cnt),
        .tick   (tick)
    );

    always_comb begin
        code_match = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (entry_q[i] != code_in[4*i +: 4]) begin
                code_match = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        idx_d   = idx_q;
        entry_d = entry_q;
        wait_d  = wait_q;
`ifdef CODE_ENTRY_LOCKOUT_EN
        fails_d = fails_q;
`endif
        unique case (state_q)
            IDLE, COUNT: begin
                state_d = enb_cnt ? COUNT : IDLE;
                // Select beats a coincident tick, so the pre-tick digit is stored.
                if (select) begin
                    entry_d[idx_q] = digit_q;
                    digit_d        = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (tick) begin
                    digit_d = next_digit(digit_q);
                end
            end
            CHECK: begin
                wait_d = '0;
                if (code_match) begin
                    state_d = OPEN;
`ifdef CODE_ENTRY_LOCKOUT_EN
                    fails_d = '0;
                end else if (fails_q == 2'd2) begin
                    state_d = LOCKOUT;
                end else begin
                    state_d = FAIL;
                    fails_d = fails_q + 2'd1;
                end
`else
                end else begin
                    state_d = FAIL;
                end
`endif
            end
            OPEN: begin
                state_d = OPEN;
            end
            FAIL: begin
                if (wait_q == WAIT_W'(FAIL_CYCLES - 1)) begin
                    state_d = IDLE;
                    digit_d = '0;
                    idx_d   = '0;
                    entry_d = '{default: '0};
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
`ifdef CODE_ENTRY_LOCKOUT_EN
            LOCKOUT: begin
                if (wait_q == WAIT_W'(LOCK_CYCLES - 1)) begin
                    state_d = IDLE;
                    digit_d = '0;
                    idx_d   = '0;
                    entry_d = '{default: '0};
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides everything above; only the lockout is immune to it.
`ifdef CODE_ENTRY_LOCKOUT_EN
        if (clear && (state_q != LOCKOUT)) begin
`else
        if (clear) begin
`endif
            state_d = IDLE;
            digit_d = '0;
            idx_d   = '0;
            entry_d = '{default: '0};
            wait_d  = '0;
        end
    end

    // Status flags are registered from the next state so they change with it.
    always_comb begin
        unlocked_d = (state_d == OPEN);
        error_d    = (state_d == FAIL);
        disable_d  = (state_d == CHECK) || (state_d == OPEN) || (state_d == FAIL);
`ifdef CODE_ENTRY_LOCKOUT_EN
        error_d    = error_d || (state_d == LOCKOUT);
        disable_d  = disable_d || (state_d == LOCKOUT);
`endif
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            digit_q    <= '0;
            idx_q      <= '0;
            // NOTE: the entry store is a handful of flops, so it is reset like any other state.
            entry_q    <= '{default: '0};
            wait_q     <= '0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
            disable_q  <= 1'b0;
`ifdef CODE_ENTRY_LOCKOUT_EN
            fails_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            idx_q      <= idx_d;
            entry_q    <= entry_d;
            wait_q     <= wait_d;
            unlocked_q <= unlocked_d;
            error_q    <= error_d;
            disable_q  <= disable_d;
`ifdef CODE_ENTRY_LOCKOUT_EN
            fails_q    <= fails_d;
`endif
        end
    end

    assign digit       = digit_q;
    assign entry_idx   = idx_q;
    assign disable_cnt = disable_q;
    assign unlocked    = unlocked_q;
    assign error       = error_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Self-checking bench for code_entry_ctrl: table of full code entries plus
// directed sequences for tick timing, wrap, reset, clear and lockout.
module tb_code_entry_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int NUM_DIGITS  = 4;
    localparam int FAIL_CYCLES = 8;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        enb_cnt;
    logic        select;
    logic        clear;
    logic [15:0] code_in;
    logic [3:0]  digit;
    logic [1:0]  entry_idx;
    logic        disable_cnt;
    logic        unlocked;
    logic        error;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_in = ~clk_in;

    code_entry_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .NUM_DIGITS  (NUM_DIGITS),
        .FAIL_CYCLES (FAIL_CYCLES)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enb_cnt     (enb_cnt),
        .select      (select),
        .clear       (clear),
        .code_in     (code_in),
        .digit       (digit),
        .entry_idx   (entry_idx),
        .disable_cnt (disable_cnt),
        .unlocked    (unlocked),
        .error       (error)
    );

    typedef struct {
        logic [15:0] code;
        logic [15:0] entry;
        logic        exp_unlock;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Count until the digit shows k, then commit it with a one-cycle select.
    task automatic enter_digit(input logic [3:0] k, input int pos);
        int n;
        n = 0;
        enb_cnt = 1'b1;
        while ((digit != k) && (n < 200)) begin
            step();
            n++;
        end
        check("digit_reached", 32'(digit == k), 1);
        select = 1'b1;
        step();
        select = 1'b0;
        check("digit_zeroed", digit, 0);
        check("entry_idx_next", entry_idx, (pos + 1) % 4);
    endtask

    task automatic enter_code(input logic [15:0] e);
        for (int i = 0; i < 4; i++) begin
            enter_digit(e[4*i +: 4], i);
        end
    endtask

    initial begin
        int cnt;
        int n;

        vecs[0] = '{16'h4321, 16'h4321, 1'b1};
        vecs[1] = '{16'h4321, 16'h5321, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b0};
        vecs[4] = '{16'h9999, 16'h9999, 1'b1};
        vecs[5] = '{16'h9090, 16'h9090, 1'b1};

        rst     = 1'b1;
        enb_cnt = 1'b0;
        select  = 1'b0;
        clear   = 1'b0;
        code_in = 16'h0000;
        #12;
        check("rst_digit", digit, 0);
        check("rst_idx", entry_idx, 0);
        check("rst_disable", disable_cnt, 0);
        check("rst_unlocked", unlocked, 0);
        check("rst_error", error, 0);
        rst = 1'b0;
        step();

        foreach (vecs[v]) begin
            code_in = vecs[v].code;
            enter_code(vecs[v].entry);
            check("check_disable", disable_cnt, 1);
            check("check_unlocked", unlocked, 0);
            step();
            check("tbl_unlocked", unlocked, vecs[v].exp_unlock);
            check("tbl_error", error, !vecs[v].exp_unlock);
            check("tbl_disable", disable_cnt, 1);
            if (vecs[v].exp_unlock) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
            end else begin
                repeat (FAIL_CYCLES) step();
            end
            check("tbl_idle_error", error, 0);
            check("tbl_idle_disable", disable_cnt, 0);
            check("tbl_idle_idx", entry_idx, 0);
        end

        // Wrong last digit: error held exactly FAIL_CYCLES clocks.
        code_in = 16'h4321;
        enter_code(16'h5321);
        step();
        cnt = 0;
        n   = 0;
        while (error && (n < 50)) begin
            cnt++;
            step();
            n++;
        end
        check("fail_len", cnt, FAIL_CYCLES);
        check("fail_idx", entry_idx, 0);
        check("fail_digit", digit, 0);
        check("fail_disable", disable_cnt, 0);

        // Tick latency, 9->0 wrap, then tick coincident with select at 7.
        enb_cnt = 1'b0;
        repeat (2) step();
        check("wrap_start", digit, 0);
        enb_cnt = 1'b1;
        repeat (4) step();
        check("tick_latency", digit, 0);
        step();
        check("tick_first", digit, 1);
        for (int t = 2; t <= 17; t++) begin
            repeat (4) step();
            check("tick_wrap", digit, t % 10);
        end
        repeat (3) step();
        check("pre_coincide", digit, 7);
        select = 1'b1;
        step();
        select = 1'b0;
        check("coincide_digit", digit, 0);
        check("coincide_idx", entry_idx, 1);
        code_in = 16'h0007;
        enter_digit(4'd0, 1);
        enter_digit(4'd0, 2);
        enter_digit(4'd0, 3);
        step();
        check("coincide_unlock", unlocked, 1);

        // Clear in OPEN relocks next clock.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_unlocked", unlocked, 0);
        check("clear_disable", disable_cnt, 0);

        // Dropping enb_cnt freezes the digit and restarts the tick phase.
        repeat (5) step();
        check("freeze_pre", digit, 1);
        repeat (2) step();
        enb_cnt = 1'b0;
        repeat (10) step();
        check("freeze_hold", digit, 1);
        enb_cnt = 1'b1;
        repeat (4) step();
        check("freeze_restart", digit, 1);
        step();
        check("freeze_tick", digit, 2);

        // Clear wins over a simultaneous select.
        select = 1'b1;
        step();
        check("sel_idx", entry_idx, 1);
        clear = 1'b1;
        step();
        select = 1'b0;
        clear  = 1'b0;
        check("clr_sel_idx", entry_idx, 0);
        check("clr_sel_digit", digit, 0);

        // Reset mid-entry discards partial state; a full entry then unlocks.
        code_in = 16'h4321;
        enter_digit(4'd1, 0);
        enter_digit(4'd2, 1);
        rst = 1'b1;
        #2;
        check("mid_rst_idx", entry_idx, 0);
        check("mid_rst_digit", digit, 0);
        check("mid_rst_flags", {disable_cnt, unlocked, error}, 0);
        rst = 1'b0;
        enter_code(16'h4321);
        step();
        check("post_rst_unlock", unlocked, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;

`ifdef CODE_ENTRY_LOCKOUT_EN
        // Three straight failures: lockout with error held and clear ignored.
        code_in = 16'h4321;
        for (int f = 0; f < 3; f++) begin
            enter_code(16'h0000);
            step();
            check("lock_err_on", error, 1);
            if (f < 2) begin
                repeat (FAIL_CYCLES) step();
                check("lock_fail_done", error, 0);
            end
        end
        check("lock_disable", disable_cnt, 1);
        cnt = 0;
        n   = 0;
        while (error && (n < 1000)) begin
            cnt++;
            clear = (n == 100);
            step();
            n++;
        end
        clear = 1'b0;
        check("lock_len", cnt, 64 * FAIL_CYCLES);
        check("lock_exit_disable", disable_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
